serial_reg_file: RTL and testbench

- Small register file of N_REG byte-wide registers reached over a 1-bit serial command interface (DIN/DOUT plus WR_EN/RD_EN start strobes).
- Each register has a parameter-assigned address.
- The last register (index N_REG-1) is a read-only constant.
- Sits behind a simple serial configuration bus; a host bit-bangs address and data MSB first.

---
 rtl/serial_reg_file.sv | 193 +++++++++++++++++++
 tb/tb_serial_reg_file.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_reg_file.sv
// serial_reg_file: byte-wide register file behind a 1-bit serial command bus.
// A host strobes WR_EN or RD_EN for one cycle, then shifts the address
// (and, for writes, the data) in on DIN MSB first. Reads return the selected
// register on DOUT, MSB first, after a single turnaround cycle.
// The highest-index register is a read-only constant; unmatched addresses
// read as zero and swallow writes silently.
module serial_reg_file #(
    parameter int                    N_REG            = 5,
    parameter int                    ADDR_WIDTH       = 8,
    parameter int                    DATA_WIDTH       = 8,
    parameter logic [DATA_WIDTH-1:0] DATA_VALUE_REG_5 = 8'h33,
    parameter logic [ADDR_WIDTH-1:0] ADDR [N_REG-1:0] = '{8'h55, 8'h06, 8'hA1, 8'h78, 8'h34}
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic WR_EN,
    input  logic RD_EN,
    input  logic DIN,
    output logic DOUT
);

    // One counter serves both the address and data phases, so size it
    // for the longer of the two fields.
    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = $clog2(MAX_W + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_ADDR = 3'd1,
        W_DATA = 3'd2,
        R_ADDR = 3'd3,
        R_TURN = 3'd4,
        R_DATA = 3'd5
    } state_t;

    // Despite its name, RSTN is an active-high synchronous reset.
    logic srst;
    assign srst = RSTN;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   data_reg, data_next;
    logic [DATA_WIDTH-1:0]   out_reg, out_next;
    logic                    dout_reg, dout_next;

    logic                    wr_commit;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [N_REG-1:0]        match;
    logic [DATA_WIDTH-1:0]   rd_term [N_REG-1:0];
    logic [DATA_WIDTH-1:0]   rd_value;

    assign DOUT = dout_reg;

    // Address decode, storage and per-register read terms. The address
    // register holds the complete address from the end of the address phase
    // until the next command starts shifting, which covers both the write
    // commit cycle and the read turnaround cycle.
    generate
        for (genvar gi = 0; gi < N_REG; gi++) begin : g_reg
            assign match[gi] = (addr_reg == ADDR[gi]);

            if (gi < N_REG - 1) begin : g_rw
                logic [DATA_WIDTH-1:0] value_reg;

                // Writable register: loads on the last data bit of a matching write.
                always_ff @(posedge CLK) begin
                    if (srst) begin
                        value_reg <= '0;
                    end else if (wr_commit && match[gi]) begin
                        value_reg <= wr_data;
                    end
                end

                assign rd_term[gi] = match[gi] ? value_reg : '0;
            end else begin : g_ro
                // Read-only constant; writes to this address are dropped.
                assign rd_term[gi] = match[gi] ? DATA_VALUE_REG_5 : '0;
            end
        end
    endgenerate

    // Read mux: addresses are distinct, so at most one term is non-zero and
    // an unmatched address naturally yields zero.
    always_comb begin
        rd_value = '0;
        for (int i = 0; i < N_REG; i++) begin
            rd_value = rd_value | rd_term[i];
        end
    end

    // Next-state, shifter and output logic for the command sequencer.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        out_next   = out_reg;
        dout_next  = 1'b0;
        wr_commit  = 1'b0;
        wr_data    = (data_reg << 1) | DATA_WIDTH'(DIN);

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                // Write takes priority when both strobes arrive together.
                if (WR_EN) begin
                    state_next = W_ADDR;
                end else if (RD_EN) begin
                    state_next = R_ADDR;
                end
            end

            W_ADDR, R_ADDR: begin
                addr_next = (addr_reg << 1) | ADDR_WIDTH'(DIN);
                if (cnt_reg == ADDR_LAST) begin
                    cnt_next   = '0;
                    state_next = (state_reg == W_ADDR) ? W_DATA : R_TURN;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            W_DATA: begin
                data_next = wr_data;
                if (cnt_reg == DATA_LAST) begin
                    wr_commit = 1'b1;
                    cnt_next  = '0;
                    // A strobe alongside the last data bit chains the next
                    // command with no idle cycle in between.
                    if (WR_EN) begin
                        state_next = W_ADDR;
                    end else if (RD_EN) begin
                        state_next = R_ADDR;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            R_TURN: begin
                // MSB goes straight to DOUT; the shifter keeps the rest.
                dout_next  = rd_value[DATA_WIDTH-1];
                out_next   = rd_value << 1;
                cnt_next   = '0;
                state_next = R_DATA;
            end

            R_DATA: begin
                if (cnt_reg == DATA_LAST) begin
                    // All bits have been presented; drop DOUT and go idle.
                    dout_next  = 1'b0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    dout_next = out_reg[DATA_WIDTH-1];
                    out_next  = out_reg << 1;
                    cnt_next  = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Sequencer state and datapath registers; reset aborts any transaction.
    always_ff @(posedge CLK) begin
        if (srst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            out_reg   <= '0;
            dout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            out_reg   <= out_next;
            dout_reg  <= dout_next;
        end
    end

endmodule

// File: tb/tb_serial_reg_file.sv
// tb_serial_reg_file: directed bench for serial_reg_file. A high-level model
// (address -> byte map) predicts read data; expected DOUT bits are scheduled
// per clock edge and a single compare process checks DOUT on every cycle.
module tb_serial_reg_file;

    logic CLK   = 1'b0;
    logic RSTN  = 1'b1;
    logic WR_EN = 1'b0;
    logic RD_EN = 1'b0;
    logic DIN   = 1'b0;
    logic DOUT;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    bit check_en = 1'b0;

    // Expected DOUT value after a given rising edge; absent means 0.
    bit exp_dout [int];

    // Model: mapped writable addresses and their contents.
    logic [7:0] model_regs [logic [7:0]];

    serial_reg_file dut (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .WR_EN (WR_EN),
        .RD_EN (RD_EN),
        .DIN   (DIN),
        .DOUT  (DOUT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_n++;

    // Per-cycle DOUT comparison against the schedule.
    always @(negedge CLK) begin
        if (check_en) begin
            bit e;
            e = exp_dout.exists(edge_n) ? exp_dout[edge_n] : 1'b0;
            checks++;
            if (DOUT !== e) begin
                errors++;
                $display("FAIL dout_cycle edge=%0d got=%b want=%b", edge_n, DOUT, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void model_reset();
        model_regs.delete();
        model_regs[8'h34] = 8'h00;
        model_regs[8'h78] = 8'h00;
        model_regs[8'hA1] = 8'h00;
        model_regs[8'h06] = 8'h00;
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        if (a == 8'h55) return 8'h33;
        if (model_regs.exists(a)) return model_regs[a];
        return 8'h00;
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [7:0] d);
        if (model_regs.exists(a)) model_regs[a] = d;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTN = 1'b1;
        tick();
        tick();
        RSTN = 1'b0;
        model_reset();
        check_en = 1'b1;
        $display("reset");
    endtask

    // strobe: 0 none (chained), 1 WR_EN, 2 WR_EN+RD_EN.
    // chain:  0 none, 1 WR_EN on last data bit, 2 RD_EN on last data bit.
    task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                            input int strobe, input int chain);
        if (strobe != 0) begin
            WR_EN = 1'b1;
            RD_EN = (strobe == 2);
            tick();
            WR_EN = 1'b0;
            RD_EN = 1'b0;
        end
        for (int i = 7; i >= 0; i--) begin
            DIN = a[i];
            tick();
        end
        for (int i = 7; i >= 0; i--) begin
            DIN = d[i];
            if (i == 0) begin
                WR_EN = (chain == 1);
                RD_EN = (chain == 2);
            end
            tick();
        end
        WR_EN = 1'b0;
        RD_EN = 1'b0;
        DIN   = 1'b0;
        model_write(a, d);
        $display("write addr=%02h data=%02h strobe=%0d chain=%0d", a, d, strobe, chain);
    endtask

    // Read with a hand-computed literal expectation that also pins the model.
    task automatic do_read(input logic [7:0] a, input logic [7:0] lit, input bit strobe);
        int k;
        logic [7:0] m;
        logic [7:0] got;
        if (strobe) begin
            RD_EN = 1'b1;
            tick();
            RD_EN = 1'b0;
        end
        k = edge_n;
        m = model_read(a);
        for (int j = 0; j < 8; j++) exp_dout[k + 9 + j] = m[7 - j];
        for (int i = 7; i >= 0; i--) begin
            DIN = a[i];
            tick();
        end
        DIN = 1'b0;
        tick();
        got[7] = DOUT;
        for (int i = 6; i >= 0; i--) begin
            tick();
            got[i] = DOUT;
        end
        tick();
        checks++;
        if (m !== lit) begin
            errors++;
            $display("FAIL model_pin addr=%02h model=%02h want=%02h", a, m, lit);
        end
        checks++;
        if (got !== lit) begin
            errors++;
            $display("FAIL read_byte addr=%02h got=%02h want=%02h", a, got, lit);
        end
        $display("read  addr=%02h data=%02h expect=%02h", a, got, lit);
    endtask

    // Write aborted by reset in the middle of its data phase.
    task automatic do_abort_write(input logic [7:0] a, input logic [7:0] d);
        WR_EN = 1'b1;
        tick();
        WR_EN = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            DIN = a[i];
            tick();
        end
        for (int i = 7; i >= 4; i--) begin
            DIN = d[i];
            tick();
        end
        DIN  = 1'b0;
        RSTN = 1'b1;
        tick();
        RSTN = 1'b0;
        model_reset();
        $display("abort write addr=%02h data=%02h by reset", a, d);
    endtask

    initial begin
        do_reset();
        tick();

        do_read(8'h34, 8'h00, 1'b1);
        do_read(8'h78, 8'h00, 1'b1);
        do_read(8'hA1, 8'h00, 1'b1);
        do_read(8'h06, 8'h00, 1'b1);
        do_read(8'h55, 8'h33, 1'b1);

        do_write(8'h34, 8'h10, 1, 0);
        do_read(8'h34, 8'h10, 1'b1);

        do_write(8'h34, 8'h10, 1, 0);
        do_write(8'h78, 8'h01, 1, 0);
        do_write(8'hA1, 8'h00, 1, 0);
        do_write(8'h06, 8'h55, 1, 0);
        do_read(8'h34, 8'h10, 1'b1);
        do_read(8'h78, 8'h01, 1'b1);
        do_read(8'hA1, 8'h00, 1'b1);
        do_read(8'h06, 8'h55, 1'b1);
        do_read(8'h55, 8'h33, 1'b1);

        // Back-to-back writes, second strobe on first's last data bit.
        do_write(8'h34, 8'h00, 1, 1);
        do_write(8'h78, 8'h55, 0, 0);
        do_read(8'h34, 8'h00, 1'b1);
        do_read(8'h78, 8'h55, 1'b1);

        // Read-only and unmapped writes are discarded.
        do_write(8'h55, 8'hFF, 1, 0);
        do_read(8'h55, 8'h33, 1'b1);
        do_write(8'h12, 8'hAB, 1, 0);
        do_read(8'h12, 8'h00, 1'b1);
        do_read(8'h34, 8'h00, 1'b1);
        do_read(8'h78, 8'h55, 1'b1);
        do_read(8'hA1, 8'h00, 1'b1);
        do_read(8'h06, 8'h55, 1'b1);

        // Write chained straight into a read of the same register.
        do_write(8'h78, 8'hC3, 1, 2);
        do_read(8'h78, 8'hC3, 1'b0);

        // Reset during a write's data phase.
        do_write(8'h34, 8'h10, 1, 0);
        do_read(8'h34, 8'h10, 1'b1);
        do_abort_write(8'h34, 8'hAA);
        tick();
        do_read(8'h34, 8'h00, 1'b1);
        do_read(8'h78, 8'h00, 1'b1);
        do_read(8'h55, 8'h33, 1'b1);

        // Simultaneous strobes: write wins.
        do_write(8'hA1, 8'h5A, 2, 0);
        do_read(8'hA1, 8'h5A, 1'b1);

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
